packet_disassembler_var: RTL

- Splits one nbits_in-bit input packet into up to NUM_CHUNKS nbits_out-bit output chunks.
- The chunk count is selectable per packet, and the emission order (MSB-first or LSB-first) is fixed by a parameter.
- Accepts the next packet in the same cycle its last chunk leaves, giving gapless throughput.
- Sits between SPI transaction logic and narrower downstream val/rdy consumers.

---
 rtl/packet_disassembler_var.sv | 100 ++++++++++
 1 files changed

// File: rtl/packet_disassembler_var.sv
// Splits one nbits_in packet into up to NUM_CHUNKS nbits_out chunks on a val/rdy stream.
// Define PKT_DISASM_LAST_EN to add the resp_last output marking the final chunk.
module packet_disassembler_var #(
  parameter int nbits_in   = 32,
  parameter int nbits_out  = 8,
  parameter int MSB_FIRST  = 1,
  parameter int NUM_CHUNKS = (nbits_in + nbits_out - 1) / nbits_out,
  parameter int LEN_BITS   = $clog2(NUM_CHUNKS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [nbits_in-1:0]  req_msg,
  input  logic [LEN_BITS-1:0]  req_len,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [nbits_out-1:0] resp_msg
`ifdef PKT_DISASM_LAST_EN
  ,
  output logic                 resp_last
`endif
);

  localparam int IDX_BITS  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int DATA_BITS = NUM_CHUNKS * nbits_out;
  localparam logic [LEN_BITS-1:0] FULL_LEN = LEN_BITS'(NUM_CHUNKS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [LEN_BITS-1:0]   eff_len;
  logic [LEN_BITS-1:0]   idx_full;
  logic [IDX_BITS-1:0]   idx;
  logic                  busy;
  logic                  last;
  logic                  accept;

  // req_rdy depends combinationally on resp_rdy so a new packet can enter as the last chunk leaves.
  always_comb begin
    busy     = (state_q == SEND);
    last     = busy && (cnt_q == len_q - LEN_BITS'(1));
    req_rdy  = !busy || (last && resp_rdy);
    accept   = req_val && req_rdy;
    eff_len  = ((req_len == '0) || (req_len > FULL_LEN)) ? FULL_LEN : req_len;
    idx_full = (MSB_FIRST != 0) ? (len_q - LEN_BITS'(1) - cnt_q) : cnt_q;
    idx      = idx_full[IDX_BITS-1:0];
    resp_val = busy;
  end

  always_comb begin
    resp_msg = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx == IDX_BITS'(k)) begin
        resp_msg = data_q[k*nbits_out +: nbits_out];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    if (accept) begin
      data_d                = '0;
      data_d[nbits_in-1:0]  = req_msg;
      len_d                 = eff_len;
      cnt_d                 = '0;
      state_d               = SEND;
    end else if (last && resp_rdy) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (busy && resp_rdy) begin
      cnt_d = cnt_q + LEN_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= FULL_LEN;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

`ifdef PKT_DISASM_LAST_EN
  assign resp_last = last;
`endif

endmodule
